// File: rtl/mag_pkg.sv
// mag_pkg
//   Shared definitions for the magnetometer frame path.
//   Frame layout (80 bits): sensor data [79:32], timestamp [31:8],
//   marker 0x4D [7:0].
//   stream_order() rearranges a frame so that stream byte k sits in
//   bits [8k+7:8k]. The serializer can then select a byte with a plain
//   index instead of decoding a field map.
package mag_pkg;

    localparam int          MAG_FRAME_W  = 80;
    localparam logic [7:0]  MAG_MARKER   = 8'h4D;
    localparam int          SENSOR_LSB   = 32;
    localparam int          TS_LSB       = 8;
    localparam int          FRAME_BYTES  = 10;
    localparam int          SENSOR_W     = MAG_FRAME_W - SENSOR_LSB;
    localparam int          SENSOR_BYTES = SENSOR_W / 8;

    typedef logic [MAG_FRAME_W-1:0] mag_frame_t;
    typedef logic [SENSOR_W-1:0]    mag_sensor_t;

    // Stream order: marker, then timestamp MSB first, then sensor MSB first.
    function automatic mag_frame_t stream_order(input mag_frame_t f);
        mag_frame_t r;
        r = '0;
        r[7:0]   = f[7:0];
        r[15:8]  = f[TS_LSB+16 +: 8];
        r[23:16] = f[TS_LSB+8  +: 8];
        r[31:24] = f[TS_LSB    +: 8];
        for (int unsigned k = 0; k < SENSOR_BYTES; k++) begin
            r[32 + 8*k +: 8] = f[MAG_FRAME_W - 8 - 8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mag_frame_fifo.sv
// mag_frame_fifo
//   DEPTH x WIDTH synchronous FIFO with an asynchronous active-low reset.
//   A push is accepted when the FIFO is not full. It is also accepted when
//   the FIFO is full, provided a pop happens in the same cycle. A pop is
//   ignored when the FIFO is empty. Full and empty come from a separate
//   count register. The pointers are log2(DEPTH) bits wide and wrap
//   naturally.
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   push       write push_data
//   push_data  entry to write
//   pop        remove the head entry
//   pop_data   head entry (combinational read)
//   count      entries stored, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
module mag_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 80,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mag_frame_serializer.sv
// mag_frame_serializer
//   Watches the 80-bit magnetometer frame coming from the I2C interface.
//   A frame is captured when two consecutive samples are equal and the
//   sensor field differs from the last captured one. Captured frames are
//   queued in a DEPTH-entry FIFO. Each queued frame is sent as a 10-byte
//   stream over a valid/ready handshake. A frame that arrives while the
//   FIFO is full is dropped and counted, and the drop counter saturates.
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   mag_data    frame from the I2C interface (may change asynchronously)
//   byte_out    current stream byte (0x00 while idle)
//   byte_valid  byte_out is valid
//   byte_ready  consumer accepts byte_out this cycle
//   fifo_count  frames stored in the FIFO, 0..DEPTH
//   drop_count  frames dropped because the FIFO was full, saturating
//   busy        a frame is being serialized
module mag_frame_serializer
    import mag_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int FRAME_BYTES = mag_pkg::FRAME_BYTES,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(FRAME_BYTES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MAG_FRAME_W-1:0] mag_data,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic [CNT_W-1:0]       fifo_count,
    output logic [7:0]             drop_count,
    output logic                   busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]                   state;
    mag_frame_t                   s0;
    mag_frame_t                   s1;
    mag_sensor_t                  last_sensor;
    logic [FRAME_BYTES-1:0][7:0]  sh;
    logic [IDX_W-1:0]             idx;

    logic       capture;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       drop;
    mag_frame_t fifo_head;

    // Two-stage sampling of the asynchronous frame. A capture needs two
    // identical samples. A change in the timestamp field alone is ignored,
    // because only the sensor field is compared against last_sensor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= mag_data;
            s1 <= s0;
        end
    end

    assign capture  = (s0 == s1) && (s1[MAG_FRAME_W-1:SENSOR_LSB] != last_sensor);
    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
    // The FIFO takes a push while full only if the serializer pops in the
    // same cycle. Any other capture while full is a drop.
    assign drop     = capture && fifo_full && !fifo_pop;

    // last_sensor is updated even when the frame is dropped, so that a
    // reading which stays stable is counted as a single drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_sensor <= '0;
            drop_count  <= '0;
        end else begin
            if (capture) begin
                last_sensor <= s1[MAG_FRAME_W-1:SENSOR_LSB];
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    mag_frame_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MAG_FRAME_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (s1),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The popped frame is stored already rearranged into stream order, so
    // byte idx of the stream is simply sh[idx].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            sh    <= '0;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        sh    <= stream_order(fifo_head);
                        idx   <= '0;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (byte_ready) begin
                        if (idx == IDX_W'(FRAME_BYTES - 1)) begin
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state == ST_SEND);
    assign byte_valid = busy;
    assign byte_out   = busy ? sh[idx] : 8'h00;

endmodule

// File: tb/tb_mag_frame_serializer.sv
module tb_mag_frame_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] mag_data;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mag_frame_serializer #(
        .DEPTH       (4),
        .FRAME_BYTES (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mag_data   (mag_data),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .fifo_count (fifo_count),
        .drop_count (drop_count),
        .busy       (busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        rst        = 1'b0;
        mag_data   = '0;
        byte_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        mag_data   = '0;
        byte_ready = 1'b0;
        @(negedge clk);
        checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte_out: got %h expected 00", byte_out); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid: got %b expected 0", byte_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [7:0] exp [10] = '{8'h4D, 8'hA0, 8'hB0, 8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        mag_data   = {48'h0102_0304_0506, 24'hA0B0C0, 8'h4D};
        byte_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_latency_count: got %0d expected 1", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_latency_busy: got %b expected 0", busy); end
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (byte_valid !== 1'b1 || byte_out !== exp[k]) begin
                errors++;
                $display("FAIL single_byte%0d: got valid=%b byte=%h expected valid=1 byte=%h", k, byte_valid, byte_out, exp[k]);
            end
            @(negedge clk);
        end
        checks++; if (byte_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_end: got valid=%b busy=%b expected 0 0", byte_valid, busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_end_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_ts_only();
        logic seen_busy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            mag_data = {48'h0102_0304_0506, 24'(c * 7 + 1), 8'h4D};
            @(negedge clk);
            if (busy === 1'b1 || fifo_count !== 3'd0) seen_busy = 1'b1;
        end
        repeat (4) @(negedge clk);
        checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL ts_only_activity: got activity=%b expected 0", seen_busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ts_only_count: got %0d expected 0", fifo_count); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL ts_only_valid: got %b expected 0", byte_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [10] = '{8'h4D, 8'h12, 8'h34, 8'h56, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        logic [7:0] prev       = 8'h00;
        logic       prev_stall = 1'b0;
        int         n = 0;
        int         c = 0;
        int         t = 0;
        byte_ready = 1'b0;
        mag_data   = {48'hAABB_CCDD_EEFF, 24'h123456, 8'h4D};
        while (byte_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL bp_start_timeout: got valid=%b expected 1", byte_valid); end
        while (n < 10 && c < 80) begin
            if (prev_stall) begin
                checks++;
                if (byte_valid !== 1'b1 || byte_out !== prev) begin
                    errors++;
                    $display("FAIL bp_hold: got valid=%b byte=%h expected valid=1 byte=%h", byte_valid, byte_out, prev);
                end
            end
            byte_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (byte_valid === 1'b1 && byte_ready) begin
                checks++;
                if (byte_out !== exp[n]) begin
                    errors++;
                    $display("FAIL bp_byte%0d: got %h expected %h", n, byte_out, exp[n]);
                end
                n++;
            end
            prev_stall = (byte_valid === 1'b1) && !byte_ready;
            prev       = byte_out;
            @(negedge clk);
            c++;
        end
        checks++; if (n != 10) begin errors++; $display("FAIL bp_total: got %0d bytes expected 10", n); end
        checks++; if (busy !== 1'b0 || byte_valid !== 1'b0) begin errors++; $display("FAIL bp_end: got busy=%b valid=%b expected 0 0", busy, byte_valid); end
        byte_ready = 1'b0;
    endtask

    task automatic test_overflow_and_drain();
        logic [7:0] got [60];
        logic [7:0] exp_lsb [6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h17};
        int n = 0;
        int c = 0;
        byte_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            mag_data = {40'h0, 8'(16 + v), 24'h0, 8'h4D};
            repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ovf_drop: got %0d expected 1", drop_count); end
        checks++; if (byte_valid !== 1'b1 || byte_out !== 8'h4D || busy !== 1'b1) begin
            errors++; $display("FAIL ovf_hold: got valid=%b byte=%h busy=%b expected 1 4d 1", byte_valid, byte_out, busy);
        end
        // Release the stream and time a new capture so that it lands on
        // the pop edge while the FIFO is full.
        byte_ready = 1'b1;
        while (n < 60 && c < 150) begin
            if (c == 8) mag_data = {40'h0, 8'h17, 24'h0, 8'h4D};
            if (c == 11) begin
                checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_pushpop_count: got %0d expected 4", fifo_count); end
                checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL full_pushpop_drop: got %0d expected 1", drop_count); end
            end
            if (byte_valid === 1'b1) begin
                got[n] = byte_out;
                n++;
            end
            @(negedge clk);
            c++;
        end
        checks++; if (n != 60) begin errors++; $display("FAIL drain_total: got %0d bytes expected 60", n); end
        for (int f = 0; f < 6; f++) begin
            checks++;
            if (got[f*10] !== 8'h4D || got[f*10+9] !== exp_lsb[f]) begin
                errors++;
                $display("FAIL drain_frame%0d: got first=%h last=%h expected first=4d last=%h", f, got[f*10], got[f*10+9], exp_lsb[f]);
            end
        end
        checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL drain_end: got busy=%b count=%0d expected 0 0", busy, fifo_count); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp [10] = '{8'h4D, 8'h01, 8'h02, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE};
        int n = 0;
        int c = 0;
        int t = 0;
        byte_ready = 1'b1;
        mag_data   = {48'hDEAD_BEEF_CAFE, 24'h010203, 8'h4D};
        while (n < 4 && c < 40) begin
            if (byte_valid === 1'b1) n++;
            @(negedge clk);
            c++;
        end
        checks++; if (n != 4 || byte_out !== 8'hDE) begin errors++; $display("FAIL mid_pre: got accepted=%0d byte=%h expected 4 de", n, byte_out); end
        rst = 1'b0;
        #1;
        checks++; if (byte_out !== 8'h00 || byte_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_out: got byte=%h valid=%b busy=%b expected 00 0 0", byte_out, byte_valid, busy);
        end
        checks++; if (fifo_count !== 3'd0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL mid_reset_counts: got count=%0d drop=%0d expected 0 0", fifo_count, drop_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        while (byte_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (byte_valid !== 1'b1 || byte_out !== exp[k]) begin
                errors++;
                $display("FAIL mid_fresh_byte%0d: got valid=%b byte=%h expected valid=1 byte=%h", k, byte_valid, byte_out, exp[k]);
            end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_fresh_end: got busy=%b expected 0", busy); end
    endtask

    task automatic test_zero_glitch();
        reset_dut();
        repeat (10) @(negedge clk);
        checks++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL zero_input: got count=%0d busy=%b expected 0 0", fifo_count, busy); end
        mag_data = {48'h1234_5678_9ABC, 24'h0, 8'h4D};
        @(negedge clk);
        mag_data = '0;
        repeat (8) @(negedge clk);
        checks++; if (fifo_count !== 3'd0 || busy !== 1'b0 || byte_valid !== 1'b0) begin
            errors++; $display("FAIL glitch: got count=%0d busy=%b valid=%b expected 0 0 0", fifo_count, busy, byte_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_ts_only();
        test_backpressure();
        test_overflow_and_drain();
        test_reset_midframe();
        test_zero_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
